// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT next-PC predictor, trained by resolved branches.
// Lookup is combinational; redirect/counters are registered one cycle after a resolve; no backpressure.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_pred_next_pc,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [TAG_BITS-1:0] res_tag;
  logic                if_hit;
  logic                res_hit;
  logic [31:0]         actual_pc;
  logic                mispred_now;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign res_idx = res_pc[IDX_BITS+1:2];
  assign res_tag = res_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is not visible yet.
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken   = if_hit && ctr_q[if_idx][1];
  assign pred_next_pc = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

  assign res_hit     = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  assign actual_pc   = res_taken ? res_target : res_pc + 32'd4;
  assign mispred_now = res_valid && (actual_pc != res_pred_next_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (res_valid) begin
      if (res_hit) begin
        if (res_taken) begin
          if (ctr_q[res_idx] != 2'b11) ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
          tgt_q[res_idx] <= res_target;
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
        end
      end else if (res_taken) begin
        // Taken miss replaces whatever aliased into this slot.
        valid_q[res_idx] <= 1'b1;
        tag_q[res_idx]   <= res_tag;
        tgt_q[res_idx]   <= res_target;
        ctr_q[res_idx]   <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      mispredict <= mispred_now;
      if (mispred_now) redirect_pc <= actual_pc;
      if (res_valid && br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
      if (mispred_now && mispred_count != 32'hFFFF_FFFF) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: redirect expectations queued at resolve time, checked one edge later.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic [31:0] res_pred_next_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .res_valid        (res_valid),
    .res_pc           (res_pc),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .res_pred_next_pc (res_pred_next_pc),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_mis;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endfunction

  task automatic lookup(input logic [31:0] pc, input logic tk, input logic [31:0] nxt);
    if_pc = pc;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
    chk("pred_next_pc", pred_next_pc, nxt);
  endtask

  // Drive a resolve and queue the redirect/count outcome the model expects.
  task automatic start_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [31:0] pnext);
    logic [31:0] act;
    exp_t        e;
    res_valid        = 1'b1;
    res_pc           = pc;
    res_taken        = tk;
    res_target       = tgt;
    res_pred_next_pc = pnext;
    act   = tk ? tgt : pc + 32'd4;
    e.mis = (act != pnext);
    if (e.mis) m_redir = act;
    e.pc = m_redir;
    sb.push_back(e);
    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
    if (e.mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
  endtask

  task automatic finish_res();
    exp_t e;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
      chk("redirect_pc", redirect_pc, e.pc);
    end
    chk("br_count", br_count, m_br);
    chk("mispred_count", mispred_count, m_mis);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [31:0] pnext);
    start_res(pc, tk, tgt, pnext);
    finish_res();
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    chk("mispredict_pulse", {31'd0, mispredict}, 32'd0);
    chk("redirect_hold", redirect_pc, m_redir);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_pc = 32'h400; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    res_target = '0; res_pred_next_pc = '0;
    m_redir = '0; m_br = '0; m_mis = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    lookup(32'h400, 1'b0, 32'h404);
    chk("reset_mispredict", {31'd0, mispredict}, 32'd0);
    chk("reset_redirect", redirect_pc, 32'd0);
    chk("reset_br_count", br_count, 32'd0);
    chk("reset_mispred_count", mispred_count, 32'd0);
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocate on taken miss
    resolve(32'h400, 1'b1, 32'h480, 32'h404);
    lookup(32'h400, 1'b1, 32'h480);
    idle_check();

    // Not-taken training: 10 -> 01 -> 00 -> 00
    resolve(32'h400, 1'b0, 32'h480, 32'h480);
    lookup(32'h400, 1'b0, 32'h404);
    resolve(32'h400, 1'b0, 32'h480, 32'h404);
    resolve(32'h400, 1'b0, 32'h480, 32'h404);
    lookup(32'h400, 1'b0, 32'h404);
    // One taken from the floor only reaches 01
    resolve(32'h400, 1'b1, 32'h480, 32'h404);
    lookup(32'h400, 1'b0, 32'h404);
    resolve(32'h400, 1'b1, 32'h4C0, 32'h404);
    lookup(32'h400, 1'b1, 32'h4C0);
    // Saturate high, then one not-taken still predicts taken
    resolve(32'h400, 1'b1, 32'h4C0, 32'h4C0);
    resolve(32'h400, 1'b1, 32'h4C0, 32'h4C0);
    resolve(32'h400, 1'b0, 32'h4C0, 32'h4C0);
    lookup(32'h400, 1'b1, 32'h4C0);

    // Aliasing: same index, different tag replaces the entry
    resolve(32'h1400, 1'b1, 32'h2000, 32'h1404);
    lookup(32'h400, 1'b0, 32'h404);
    lookup(32'h1400, 1'b1, 32'h2000);
    resolve(32'h400, 1'b0, 32'h480, 32'h404);
    lookup(32'h1400, 1'b1, 32'h2000);

    // Same-cycle lookup sees pre-update contents
    start_res(32'h844, 1'b1, 32'h900, 32'h848);
    lookup(32'h844, 1'b0, 32'h848);
    finish_res();
    lookup(32'h844, 1'b1, 32'h900);

    // Mid-operation reset while mispredict is high
    resolve(32'h844, 1'b0, 32'h900, 32'h900);
    rst_n = 1'b0;
    #1;
    chk("arst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("arst_redirect", redirect_pc, 32'd0);
    chk("arst_br_count", br_count, 32'd0);
    chk("arst_mispred_count", mispred_count, 32'd0);
    res_valid = 1'b1; res_pc = 32'h400; res_taken = 1'b1; res_target = 32'h480;
    res_pred_next_pc = 32'h404;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    m_redir = '0; m_br = '0; m_mis = '0;
    lookup(32'h844, 1'b0, 32'h848);
    lookup(32'h1400, 1'b0, 32'h1404);
    lookup(32'h400, 1'b0, 32'h404);
    chk("post_rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("post_rst_br_count", br_count, 32'd0);

    // Counter saturation from a preloaded near-max value
    @(negedge clk);
    force dut.br_count = 32'hFFFF_FFFE;
    force dut.mispred_count = 32'hFFFF_FFFE;
    #1;
    release dut.br_count;
    release dut.mispred_count;
    m_br = 32'hFFFF_FFFE;
    m_mis = 32'hFFFF_FFFE;
    resolve(32'h600, 1'b1, 32'h700, 32'h604);
    resolve(32'h600, 1'b1, 32'h780, 32'h700);
    resolve(32'h600, 1'b1, 32'h780, 32'h780);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
